fizzbuzz_stream_gen: RTL and testbench
======================================

// Module: fizzbuzz_stream_gen
// PURPOSE
//  Generates the FizzBuzz sequence 1..limit as a valid/ready token stream. It is the producing
//  end of the fizz/buzz classification interface: one token per number, tagged NUM/FIZZ/BUZZ/FIZZBUZZ.
//  Divisibility comes from wrap-around mod-3/mod-5 residue counters; there is no divider or multiplier.
//  Sits between a host start/limit register and a downstream consumer (checker, UART, FIFO).
// PARAMETERS
//  WIDTH   8   counter/limit width; numbers range 1..2^WIDTH-1
// PORTS
//  clk       in   1      clock; all state on rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      1-cycle request; sampled only when busy=0
//  limit     in   WIDTH  last number to emit; captured on accepted start
//  busy      out  1      high from cycle after accepted start until final beat accepted
//  done      out  1      1-cycle pulse when the sequence completes
//  m_valid   out  1      output beat valid
//  m_ready   in   1      consumer ready; transfer when m_valid & m_ready
//  m_kind    out  2      fizzbuzz_pkg::fb_kind_t of current number
//  m_number  out  WIDTH  current number (binary)
//  m_eol     out  1      last beat of current number (always 1 without FIZZBUZZ_ASCII_EN)
//  m_char    out  8      ASCII byte; present only with FIZZBUZZ_ASCII_EN
// BEHAVIOUR
//  - Reset: busy=0, done=0, m_valid=0, m_kind=FB_NUM, m_number=0, m_eol=0, m_char=0, FSM=IDLE,
//    n=0, r3=0, r5=0. Reset mid-sequence aborts silently: no done, no further beats.
//  - FSM: IDLE -> EMIT on start & limit!=0; EMIT -> FINISH when the beat with m_eol=1 and
//    m_number==limit is accepted; FINISH -> IDLE after 1 cycle (done=1 in FINISH).
//    IDLE with start & limit==0 -> FINISH directly (done one cycle after start, zero beats).
//  - Latency: start sampled in cycle 0 -> m_valid=1, m_number=1 in cycle 1.
//  - Handshake: all m_* are registered; while m_valid & !m_ready, every m_* stays stable.
//    m_valid never drops without a transfer. With m_ready held high, one beat per cycle.
//  - Classification: r3/r5 advance with n (wrap 2->0, 4->0). kind = FIZZBUZZ if r3==0&r5==0,
//    FIZZ if r3==0, BUZZ if r5==0, else NUM. Residues start at r3=1, r5=1 for n=1.
//  - Width: n stops at limit; never increments past 2^WIDTH-1 (limit=all-ones must not wrap to 0).
//  - start while busy is ignored; limit changes while busy are ignored.
//  - done and a transfer never coincide; done is asserted with m_valid=0.
// CONFIGURATION
//  FIZZBUZZ_ASCII_EN defined: each number becomes multiple byte beats on m_char:
//    "Fizz\n", "Buzz\n", "FizzBuzz\n", or the decimal digits without leading zeros followed by "\n".
//    m_eol=1 only on the '\n' beat. m_kind/m_number hold steady across all beats of one number.
//    Decimal digits come from a BCD counter stepped in lockstep with n; no division.
//  Not defined: one beat per number; m_char port absent; m_eol tied 1; no BCD logic.
// STRUCTURE
//  fizzbuzz_pkg: fb_kind_t enum {FB_NUM=0,FB_FIZZ=1,FB_BUZZ=2,FB_FIZZBUZZ=3}; FSM state enum
//    {IDLE,EMIT,FINISH}; ASCII constants ("Fizz","Buzz",'\n','0'); function bcd_digits(WIDTH).
//  Sub-module (ASCII build only): fizzbuzz_bcd_counter: clear + increment, DIGITS BCD nibbles,
//    outputs digit vector and index of the most significant non-zero digit.
// TESTING
//  1 limit=15, m_ready=1 -> 15 beats, numbers 1..15, kinds N N F N B F N N F B N F N N FB;
//    done in cycle 16; busy low in cycle 17.
//  2 limit=0 -> zero beats, done exactly one cycle after start, busy never high.
//  3 limit=6, m_ready random 50%, pulse start mid-run -> data stable while stalled,
//    exactly 6 beats, second start ignored.
//  4 limit=255 -> 255 beats; last beat number=255, kind=FIZZBUZZ; no beat with number 0.
//  5 rst_n low after 5th beat -> all outputs take reset values, no done; then limit=3 ->
//    beats 1,2,3 (N,N,F).
//  6 FIZZBUZZ_ASCII_EN, limit=10, m_ready=1 -> 35 bytes "1\n2\nFizz\n4\nBuzz\nFizz\n7\n8\nFizz\nBuzz\n",
//    m_eol on each '\n'; limit=100 -> last bytes "Buzz\n", and beat 97 prints "97\n".

Source files
------------

// File: rtl/fizzbuzz_stream_gen_pkg.sv
// fizzbuzz_pkg
// Shared types and helpers for the FizzBuzz stream generator.
//   fb_kind_t   classification tag carried with every output beat
//   fb_state_t  sequencer states
//   classify()  kind from the mod-3 / mod-5 residues
// Optional feature macro: FIZZBUZZ_ASCII_EN
//   adds the ASCII text constants and bcd_digits(), used only by the byte-stream build.
package fizzbuzz_pkg;

    typedef enum logic [1:0] {
        FB_NUM      = 2'd0,
        FB_FIZZ     = 2'd1,
        FB_BUZZ     = 2'd2,
        FB_FIZZBUZZ = 2'd3
    } fb_kind_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } fb_state_t;

    // A residue of zero means the number is a multiple of 3 (r3) or 5 (r5).
    function automatic fb_kind_t classify(input logic [1:0] r3, input logic [2:0] r5);
        fb_kind_t kind;
        if (r3 == 2'd0 && r5 == 3'd0) begin
            kind = FB_FIZZBUZZ;
        end else if (r3 == 2'd0) begin
            kind = FB_FIZZ;
        end else if (r5 == 3'd0) begin
            kind = FB_BUZZ;
        end else begin
            kind = FB_NUM;
        end
        return kind;
    endfunction

`ifdef FIZZBUZZ_ASCII_EN
    localparam logic [31:0] FIZZ_STR  = "Fizz";
    localparam logic [31:0] BUZZ_STR  = "Buzz";
    localparam logic [7:0]  CHAR_NL   = 8'h0A;
    localparam logic [7:0]  CHAR_ZERO = 8'h30;

    // Number of decimal digits needed for the largest WIDTH-bit value.
    // Evaluated at elaboration only; no divider reaches hardware.
    function automatic int bcd_digits(input int width);
        longint unsigned v;
        int              d;
        v = (64'd1 << width) - 64'd1;
        d = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                v = v / 64'd10;
                d = d + 1;
            end
        end
        if (d == 0) begin
            d = 1;
        end
        return d;
    endfunction
`endif

endpackage

// File: rtl/fizzbuzz_stream_gen_if.sv
// fizzbuzz_stream_gen_if
// Valid/ready token stream from the FizzBuzz generator to its consumer.
//   m_valid  producer has a beat      m_ready  consumer accepts it
//   m_kind   NUM/FIZZ/BUZZ/FIZZBUZZ   m_number current number
//   m_eol    last beat of the number  m_char   ASCII byte (FIZZBUZZ_ASCII_EN only)
// Optional feature macro: FIZZBUZZ_ASCII_EN
interface fizzbuzz_stream_gen_if #(
    parameter int WIDTH = 8
);
    import fizzbuzz_pkg::*;

    logic             m_valid;
    logic             m_ready;
    fb_kind_t         m_kind;
    logic [WIDTH-1:0] m_number;
    logic             m_eol;
`ifdef FIZZBUZZ_ASCII_EN
    logic [7:0]       m_char;

    modport master (output m_valid, m_kind, m_number, m_eol, m_char, input m_ready);
    modport slave  (input m_valid, m_kind, m_number, m_eol, m_char, output m_ready);
`else
    modport master (output m_valid, m_kind, m_number, m_eol, input m_ready);
    modport slave  (input m_valid, m_kind, m_number, m_eol, output m_ready);
`endif

endinterface

// File: rtl/fizzbuzz_stream_gen_bcd_counter.sv
// fizzbuzz_bcd_counter
// Decimal counter that tracks the current number so its digits can be printed
// without division. Present only in the FIZZBUZZ_ASCII_EN build.
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       restart from zero (clear together with incr yields 1)
//   incr        add one
//   digits_nx   BCD value the counter holds after this edge
//   msd_nx      index of the most significant non-zero digit of digits_nx
// Optional feature macro: FIZZBUZZ_ASCII_EN
`ifdef FIZZBUZZ_ASCII_EN
module fizzbuzz_bcd_counter #(
    parameter int DIGITS = 3,
    parameter int IDX_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                incr,
    output logic [4*DIGITS-1:0] digits_nx,
    output logic [IDX_W-1:0]    msd_nx
);

    logic [4*DIGITS-1:0] digits_q;
    logic [4*DIGITS-1:0] digits_d;

    // Ripple a decimal carry from the least significant digit upwards.
    always_comb begin
        logic [4*DIGITS-1:0] base;
        logic [3:0]          nib;
        logic                carry;
        base     = clear ? '0 : digits_q;
        carry    = incr;
        nib      = 4'd0;
        digits_d = base;
        for (int i = 0; i < DIGITS; i++) begin
            nib = base[4*i +: 4];
            if (carry) begin
                if (nib == 4'd9) begin
                    nib = 4'd0;
                end else begin
                    nib   = nib + 4'd1;
                    carry = 1'b0;
                end
            end
            digits_d[4*i +: 4] = nib;
        end
    end

    // Highest non-zero digit decides where the printed number starts.
    always_comb begin
        msd_nx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits_d[4*i +: 4] != 4'd0) begin
                msd_nx = IDX_W'(i);
            end
        end
    end

    assign digits_nx = digits_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
        end else begin
            digits_q <= digits_d;
        end
    end

endmodule
`endif

// File: rtl/fizzbuzz_stream_gen.sv
// fizzbuzz_stream_gen
// Emits the FizzBuzz sequence 1..limit as a registered valid/ready stream.
// Divisibility comes from wrap-around mod-3 / mod-5 residue counters.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request, acted on only while idle
//   limit       last number, captured with an accepted start
//   busy        a sequence is being streamed
//   done        one-cycle completion pulse (never with m_valid)
//   m           stream master port (fizzbuzz_stream_gen_if.master)
// Optional feature macro: FIZZBUZZ_ASCII_EN
//   each number becomes "Fizz\n", "Buzz\n", "FizzBuzz\n" or its decimal digits
//   plus "\n", one byte per beat on m.m_char; m_eol marks the '\n' byte.
module fizzbuzz_stream_gen
    import fizzbuzz_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      limit,
    output logic                  busy,
    output logic                  done,
    fizzbuzz_stream_gen_if.master m
);

    fb_state_t        state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [1:0]       r3_q, r3_d;
    logic [2:0]       r5_q, r5_d;
    logic             m_valid_q, m_valid_d;
    fb_kind_t         m_kind_q, m_kind_d;
    logic             m_eol_q, m_eol_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             restart;
    logic             advance;

`ifdef FIZZBUZZ_ASCII_EN
    localparam int DIGITS = bcd_digits(WIDTH);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [3:0]          idx_q, idx_d;
    logic [7:0]          m_char_q, m_char_d;
    logic                step_byte;
    logic [4*DIGITS-1:0] bcd_digits_nx;
    logic [IDX_W-1:0]    bcd_msd_nx;

    // Byte at position idx of the text for one number.
    function automatic logic [7:0] char_at(input fb_kind_t kind, input logic [3:0] idx,
                                           input logic [4*DIGITS-1:0] dig,
                                           input logic [IDX_W-1:0] msd);
        logic [7:0] c;
        int         p;
        int         top;
        p   = int'(idx);
        top = int'(msd);
        c   = CHAR_NL;
        case (kind)
            FB_FIZZ:     if (p < 4) c = FIZZ_STR[8*(3-p) +: 8];
            FB_BUZZ:     if (p < 4) c = BUZZ_STR[8*(3-p) +: 8];
            FB_FIZZBUZZ: begin
                if (p < 4) begin
                    c = FIZZ_STR[8*(3-p) +: 8];
                end else if (p < 8) begin
                    c = BUZZ_STR[8*(7-p) +: 8];
                end
            end
            default:     if (p <= top) c = CHAR_ZERO + {4'd0, dig[4*(top-p) +: 4]};
        endcase
        return c;
    endfunction

    // True on the '\n' position, which ends the text of one number.
    function automatic logic is_last(input fb_kind_t kind, input logic [3:0] idx,
                                     input logic [IDX_W-1:0] msd);
        logic last;
        case (kind)
            FB_FIZZ, FB_BUZZ: last = (idx == 4'd4);
            FB_FIZZBUZZ:      last = (idx == 4'd8);
            default:          last = (int'(idx) == int'(msd) + 1);
        endcase
        return last;
    endfunction

    fizzbuzz_bcd_counter #(
        .DIGITS (DIGITS),
        .IDX_W  (IDX_W)
    ) u_bcd (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (restart),
        .incr      (restart | advance),
        .digits_nx (bcd_digits_nx),
        .msd_nx    (bcd_msd_nx)
    );
`endif

    // Sequencer: every beat is built here and registered, so a stalled beat
    // stays frozen simply because nothing moves without a transfer.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        limit_d   = limit_q;
        r3_d      = r3_q;
        r5_d      = r5_q;
        m_valid_d = m_valid_q;
        m_kind_d  = m_kind_q;
        m_eol_d   = m_eol_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        restart   = 1'b0;
        advance   = 1'b0;
`ifdef FIZZBUZZ_ASCII_EN
        idx_d     = idx_q;
        m_char_d  = m_char_q;
        step_byte = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    limit_d = limit;
                    if (limit != '0) begin
                        state_d   = EMIT;
                        restart   = 1'b1;
                        n_d       = {{(WIDTH-1){1'b0}}, 1'b1};
                        r3_d      = 2'd1;
                        r5_d      = 3'd1;
                        m_valid_d = 1'b1;
                        busy_d    = 1'b1;
`ifdef FIZZBUZZ_ASCII_EN
                        idx_d     = 4'd0;
`endif
                    end else begin
                        // Empty sequence: report completion without any beat.
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (m_valid_q && m.m_ready) begin
                    if (m_eol_q) begin
                        // n never passes limit, so limit = all-ones cannot wrap.
                        if (n_q == limit_q) begin
                            state_d   = FINISH;
                            m_valid_d = 1'b0;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                        end else begin
                            advance = 1'b1;
                            n_d     = n_q + 1'b1;
                            r3_d    = (r3_q == 2'd2) ? 2'd0 : r3_q + 2'd1;
                            r5_d    = (r5_q == 3'd4) ? 3'd0 : r5_q + 3'd1;
`ifdef FIZZBUZZ_ASCII_EN
                            idx_d   = 4'd0;
`endif
                        end
                    end
`ifdef FIZZBUZZ_ASCII_EN
                    else begin
                        step_byte = 1'b1;
                        idx_d     = idx_q + 4'd1;
                    end
`endif
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (restart || advance) begin
            m_kind_d = classify(r3_d, r5_d);
        end
`ifdef FIZZBUZZ_ASCII_EN
        // The counter's next value is used so the first digit of a new number
        // is already correct in the registered byte.
        if (restart || advance || step_byte) begin
            m_char_d = char_at(m_kind_d, idx_d, bcd_digits_nx, bcd_msd_nx);
            m_eol_d  = is_last(m_kind_d, idx_d, bcd_msd_nx);
        end
`else
        if (restart || advance) begin
            m_eol_d = 1'b1;
        end
`endif
    end

    // State and output registers; reset aborts any sequence silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            limit_q   <= '0;
            r3_q      <= 2'd0;
            r5_q      <= 3'd0;
            m_valid_q <= 1'b0;
            m_kind_q  <= FB_NUM;
            m_eol_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef FIZZBUZZ_ASCII_EN
            idx_q     <= 4'd0;
            m_char_q  <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            limit_q   <= limit_d;
            r3_q      <= r3_d;
            r5_q      <= r5_d;
            m_valid_q <= m_valid_d;
            m_kind_q  <= m_kind_d;
            m_eol_q   <= m_eol_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef FIZZBUZZ_ASCII_EN
            idx_q     <= idx_d;
            m_char_q  <= m_char_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign m.m_valid  = m_valid_q;
    assign m.m_kind   = m_kind_q;
    assign m.m_number = n_q;
    assign m.m_eol    = m_eol_q;
`ifdef FIZZBUZZ_ASCII_EN
    assign m.m_char   = m_char_q;
`endif

endmodule

// File: tb/tb_fizzbuzz_stream_gen.sv
// tb_fizzbuzz_stream_gen
// Scoreboard bench for fizzbuzz_stream_gen. Expected beats are derived from
// plain k%3 / k%5 arithmetic (and $sformatf text with FIZZBUZZ_ASCII_EN) and
// queued when a run starts; a monitor pops and compares on every transfer.
// Optional feature macro: FIZZBUZZ_ASCII_EN
module tb_fizzbuzz_stream_gen;
    import fizzbuzz_pkg::*;

    typedef struct {
        int         kind;
        int         number;
        int         eol;
        logic [7:0] ch;
    } beat_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] limit;
    logic       busy;
    logic       done;

    beat_t exp_q[$];
    int    totalChecks = 0;
    int    badChecks   = 0;
    int    beats       = 0;
    int    doneCount   = 0;
    int    lastNumber  = -1;
    int    lastKind    = -1;
    int    readyMode   = 0;
    bit    prevStall   = 0;

    fizzbuzz_stream_gen_if #(.WIDTH(8)) bus ();

    fizzbuzz_stream_gen #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .limit (limit),
        .busy  (busy),
        .done  (done),
        .m     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Consumer readiness: always ready, or a coin flip per cycle.
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input string what);
        totalChecks++;
        badChecks++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    // Reference model: the FizzBuzz rules straight from arithmetic.
    function automatic int pushExpected(input int lim);
        int    cnt;
        int    kind;
        string s;
        beat_t b;
        cnt = 0;
        for (int k = 1; k <= lim; k++) begin
            if (k % 15 == 0)     kind = 3;
            else if (k % 3 == 0) kind = 1;
            else if (k % 5 == 0) kind = 2;
            else                 kind = 0;
`ifdef FIZZBUZZ_ASCII_EN
            case (kind)
                1:       s = "Fizz";
                2:       s = "Buzz";
                3:       s = "FizzBuzz";
                default: s = $sformatf("%0d", k);
            endcase
            s = {s, "\n"};
            for (int i = 0; i < s.len(); i++) begin
                b.kind   = kind;
                b.number = k;
                b.eol    = (i == s.len() - 1) ? 1 : 0;
                b.ch     = s[i];
                exp_q.push_back(b);
                cnt++;
            end
`else
            s        = "";
            b.kind   = kind;
            b.number = k;
            b.eol    = 1;
            b.ch     = 8'd0;
            exp_q.push_back(b);
            cnt++;
`endif
        end
        return cnt;
    endfunction

    // Monitor: the presented beat must always equal the queue head, so a
    // stalled beat that changes is caught as well as a wrong transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.m_valid) begin
                if (exp_q.size() == 0) begin
                    failNow("extra_beat", $sformatf("got number %0d, expected no beat", bus.m_number));
                    if (bus.m_ready) beats++;
                end else begin
                    checkOutput("m_number", int'(bus.m_number), exp_q[0].number);
                    checkOutput("m_kind", int'(bus.m_kind), exp_q[0].kind);
                    checkOutput("m_eol", int'(bus.m_eol), exp_q[0].eol);
`ifdef FIZZBUZZ_ASCII_EN
                    checkOutput("m_char", int'(bus.m_char), int'(exp_q[0].ch));
`endif
                    if (bus.m_ready) begin
                        lastNumber = int'(bus.m_number);
                        lastKind   = int'(bus.m_kind);
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end else if (prevStall) begin
                failNow("valid_dropped", "got m_valid 0 while stalled, expected 1");
            end
            prevStall = bus.m_valid && !bus.m_ready;
            if (done) begin
                doneCount++;
                checkOutput("done_without_valid", int'(bus.m_valid), 0);
            end
        end
    end

    // One full run: queue the model, pulse start, wait (bounded) for done.
    task automatic applyStimulus(input int lim, input int mode, input int pulseAt, output int got);
        int b0;
        int d0;
        int nb;
        int doneCycle;
        bit busySeen;
        readyMode = mode;
        b0        = beats;
        d0        = doneCount;
        nb        = pushExpected(lim);
        limit     = 8'(lim);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        doneCycle = -1;
        busySeen  = 0;
        for (int c = 1; c <= lim * 40 + 60; c++) begin
            if (busy) busySeen = 1;
            if (done) begin
                doneCycle = c;
                break;
            end
            if (c == pulseAt) begin
                start = 1'b1;
                limit = 8'd200;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        start = 1'b0;
        got   = beats - b0;
        if (doneCycle < 0) begin
            failNow("done_timeout", $sformatf("no done for limit %0d", lim));
        end else begin
            if (mode == 0) checkOutput("done_latency", doneCycle, nb + 1);
            checkOutput("busy_seen", int'(busySeen), (lim != 0) ? 1 : 0);
            @(posedge clk);
            #1;
            checkOutput("busy_after_done", int'(busy), 0);
            checkOutput("done_one_cycle", int'(done), 0);
            checkOutput("beat_count", got, nb);
            checkOutput("done_pulses", doneCount - d0, 1);
            checkOutput("queue_drained", exp_q.size(), 0);
        end
        exp_q.delete();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_m_valid"}, int'(bus.m_valid), 0);
        checkOutput({tag, "_m_kind"}, int'(bus.m_kind), 0);
        checkOutput({tag, "_m_number"}, int'(bus.m_number), 0);
        checkOutput({tag, "_m_eol"}, int'(bus.m_eol), 0);
`ifdef FIZZBUZZ_ASCII_EN
        checkOutput({tag, "_m_char"}, int'(bus.m_char), 0);
`endif
    endtask

    initial begin
        int got;
        int b0;
        int d0;
        bit reached;
        rst_n = 1'b0;
        start = 1'b0;
        limit = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] limit 15, always ready");
        applyStimulus(15, 0, 0, got);

        $display("[TB] limit 0");
        applyStimulus(0, 0, 0, got);
        checkOutput("limit0_beats", got, 0);

        $display("[TB] limit 6, random ready, start pulsed while busy");
        applyStimulus(6, 1, 3, got);

        $display("[TB] limit 255");
        applyStimulus(255, 0, 0, got);
        checkOutput("last_number", lastNumber, 255);
        checkOutput("last_kind", lastKind, int'(FB_FIZZBUZZ));

        $display("[TB] reset after 5th beat");
        readyMode = 0;
        b0 = beats;
        d0 = doneCount;
        void'(pushExpected(20));
        limit = 8'd20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        reached = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (beats - b0 >= 5) begin
                reached = 1;
                break;
            end
        end
        if (!reached) failNow("fifth_beat_timeout", "5 beats never transferred");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        exp_q.delete();
        prevStall = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("no_done_after_abort", int'(done), 0);
            checkOutput("no_valid_after_abort", int'(bus.m_valid), 0);
        end
        checkOutput("abort_done_pulses", doneCount - d0, 0);
        applyStimulus(3, 0, 0, got);
        checkOutput("after_reset_last", lastNumber, 3);
        checkOutput("after_reset_kind", lastKind, int'(FB_FIZZ));

        $display("[TB] random limits, random ready");
        repeat (4) begin
            applyStimulus(int'($urandom_range(1, 40)), 1, 0, got);
        end

`ifdef FIZZBUZZ_ASCII_EN
        $display("[TB] ASCII limit 10");
        applyStimulus(10, 0, 0, got);
        checkOutput("ascii_bytes_10", got, 35);
        $display("[TB] ASCII limit 100");
        applyStimulus(100, 0, 0, got);
        checkOutput("ascii_last_number", lastNumber, 100);
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
